// File: rtl/count_monitor.sv
// Sequence monitor for the mod-(MAX_COUNT+1) up-counter: hunts for a legal value,
// locks after LOCK_N correct increments, then flags skips, stalls and illegal codes.
module count_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 14,
  parameter int unsigned LOCK_N    = 3,
  parameter int unsigned UNLOCK_N  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [WIDTH-1:0] Q_IN,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR,
  output logic             ILLEGAL,
  output logic [7:0]       ERR_CNT,
  output logic [7:0]       WRAP_CNT
);

  localparam int unsigned GW = (LOCK_N   > 1) ? $clog2(LOCK_N + 1)   : 1;
  localparam int unsigned BW = (UNLOCK_N > 1) ? $clog2(UNLOCK_N + 1) : 1;
  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(MAX_COUNT);
  localparam logic [GW-1:0]    LOCKV  = GW'(LOCK_N);
  localparam logic [BW-1:0]    UNLOCKV = BW'(UNLOCK_N);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  state_t          state;
  logic [WIDTH-1:0] prev;
  logic [GW-1:0]   good_cnt;
  logic [BW-1:0]   bad_cnt;

  logic [WIDTH-1:0] nxt;
  logic             legal;
  logic             match;
  logic             err_inc;

  always_comb begin
    nxt     = (prev == MAXV) ? '0 : prev + 1'b1;
    legal   = (Q_IN <= MAXV);
    match   = legal && (Q_IN == nxt);
    err_inc = EN && (state == LOCK) && !match;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= HUNT;
      prev     <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      ILLEGAL  <= 1'b0;
      ERR_CNT  <= '0;
      WRAP_CNT <= '0;
    end else begin
      ERR     <= 1'b0;
      ILLEGAL <= 1'b0;

      // Clear wins over a pending count, but the same-cycle mismatch still lands as 1.
      if (CLR_ERR)
        ERR_CNT <= {7'd0, err_inc};
      else if (err_inc && ERR_CNT != '1)
        ERR_CNT <= ERR_CNT + 8'd1;

      if (EN) begin
        if (!legal)
          ILLEGAL <= 1'b1;
        else
          prev <= Q_IN;

        case (state)
          HUNT: begin
            if (legal) begin
              good_cnt <= '0;
              state    <= CHECK;
            end
          end
          CHECK: begin
            if (!legal) begin
              state <= HUNT;
            end else if (match) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt + 1'b1 == LOCKV) begin
                bad_cnt <= '0;
                state   <= LOCK;
                LOCKED  <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCK: begin
            if (match) begin
              bad_cnt <= '0;
              if (prev == MAXV)
                WRAP_CNT <= WRAP_CNT + 8'd1;
            end else begin
              ERR     <= 1'b1;
              bad_cnt <= bad_cnt + 1'b1;
              if (bad_cnt + 1'b1 == UNLOCKV) begin
                good_cnt <= '0;
                state    <= CHECK;
                LOCKED   <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            LOCKED <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
